// File: rtl/video_pkg.sv
// Shared video-subsystem definitions: DMA sequencer states, CPU register map,
// pixel-phase slot assignments and the objram table length.
package video_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    REQ  = 3'd2,
    XFER = 3'd3,
    REL  = 3'd4,
    DONE = 3'd5
  } dma_state_t;

  typedef enum logic [1:0] {
    CFG_SRC_LO = 2'd0,
    CFG_SRC_HI = 2'd1,
    CFG_LEN_LO = 2'd2,
    CFG_CTRL   = 2'd3
  } cfg_sel_t;

  localparam logic [2:0] PHI_RD_SLOT  = 3'd0;
  localparam logic [2:0] PHI_CAP_SLOT = 3'd2;
  localparam logic [2:0] PHI_WR_SLOT  = 3'd3;

  localparam logic [9:0] OBJRAM_LEN = 10'h180;

  // Phase slot immediately preceding the given one in the 4-slot cycle.
  function automatic logic [2:0] phi_before(input logic [2:0] slot);
    return {1'b0, slot[1:0] - 2'd1};
  endfunction

endpackage

// File: rtl/dma_cfg_regs.sv
// CPU-visible configuration registers for the sprite DMA: source address,
// transfer length and the start/abort strobes decoded from the ctrl register.
module dma_cfg_regs
  import video_pkg::*;
#(
  parameter int               ADDR_W      = 16,
  parameter int               LEN_W       = 10,
  parameter logic [LEN_W-1:0] DEFAULT_LEN = OBJRAM_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [1:0]        cfg_sel,
  input  logic [7:0]        cfg_din,
  input  logic              idle,
  output logic [ADDR_W-1:0] src,
  output logic [LEN_W-1:0]  len,
  output logic              start,
  output logic              abort
);

  logic [ADDR_W-1:0] src_reg;
  logic [LEN_W-1:0]  len_reg;
  cfg_sel_t          sel;

  assign sel = cfg_sel_t'(cfg_sel);

  // Address/length are frozen once a transfer is armed so the sequencer
  // always works from a consistent descriptor.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_reg <= '0;
      len_reg <= DEFAULT_LEN;
    end else if (cfg_wr && idle) begin
      case (sel)
        CFG_SRC_LO: src_reg[7:0]        <= cfg_din;
        CFG_SRC_HI: src_reg[ADDR_W-1:8] <= cfg_din[ADDR_W-9:0];
        CFG_LEN_LO: len_reg             <= {DEFAULT_LEN[LEN_W-1:8], cfg_din};
        default: ;
      endcase
    end
  end

  assign src   = src_reg;
  assign len   = len_reg;
  assign start = cfg_wr && (sel == CFG_CTRL) && cfg_din[0];
  assign abort = cfg_wr && (sel == CFG_CTRL) && cfg_din[1];

endmodule

// File: rtl/sprite_dma_ctrl.sv
// Sprite attribute DMA: takes the Z80 bus during vblank, copies the table from
// work RAM into the idle objram bank, then flips the bank select.
module sprite_dma_ctrl
  import video_pkg::*;
#(
  parameter int               ADDR_W      = 16,
  parameter int               LEN_W       = 10,
  parameter logic [LEN_W-1:0] DEFAULT_LEN = OBJRAM_LEN,
  parameter logic [2:0]       PHI_RD      = PHI_RD_SLOT,
  parameter logic [2:0]       PHI_CAP     = PHI_CAP_SLOT,
  parameter logic [2:0]       PHI_WR      = PHI_WR_SLOT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        phi,
  input  logic              vblank,
  input  logic              cfg_wr,
  input  logic [1:0]        cfg_sel,
  input  logic [7:0]        cfg_din,
  output logic              busrq_n,
  input  logic              busack_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_din,
  output logic [LEN_W-1:0]  obj_addr,
  output logic              obj_wr,
  output logic [7:0]        obj_dout,
  output logic              psl2,
  output logic              busy,
  output logic              done_irq
);

  dma_state_t        state_reg, state_next;
  logic [LEN_W-1:0]  count_reg, count_next, count_inc;
  logic [7:0]        data_reg, data_next;
  logic              fail_reg, fail_next;
  logic              psl2_reg, psl2_next;
  logic [ADDR_W-1:0] src;
  logic [LEN_W-1:0]  len;
  logic              start, abort;

  dma_cfg_regs #(
    .ADDR_W      (ADDR_W),
    .LEN_W       (LEN_W),
    .DEFAULT_LEN (DEFAULT_LEN)
  ) u_cfg_regs (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_wr  (cfg_wr),
    .cfg_sel (cfg_sel),
    .cfg_din (cfg_din),
    .idle    (state_reg == IDLE),
    .src     (src),
    .len     (len),
    .start   (start),
    .abort   (abort)
  );

  assign count_inc = count_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      data_reg  <= '0;
      fail_reg  <= 1'b0;
      psl2_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      data_reg  <= data_next;
      fail_reg  <= fail_next;
      psl2_reg  <= psl2_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    data_next  = data_reg;
    fail_next  = fail_reg;
    psl2_next  = psl2_reg;
    busrq_n    = 1'b1;
    mem_addr   = '0;
    mem_rd     = 1'b0;
    obj_wr     = 1'b0;
    done_irq   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          count_next = '0;
          fail_next  = 1'b0;
          state_next = (len == '0) ? DONE : ARM;
        end
      end
      ARM: begin
        if (abort)       state_next = IDLE;
        else if (vblank) state_next = REQ;
      end
      REQ: begin
        busrq_n = 1'b0;
        if (abort) begin
          fail_next  = 1'b1;
          state_next = REL;
        end else if (!busack_n && (phi == phi_before(PHI_RD))) begin
          // Line up the first cycle of XFER with the read slot.
          state_next = XFER;
        end
      end
      XFER: begin
        busrq_n  = 1'b0;
        mem_addr = src + {{(ADDR_W-LEN_W){1'b0}}, count_reg};
        // Losing vblank mid-copy leaves the new bank untrustworthy.
        if (!vblank) fail_next = 1'b1;
        if (abort) begin
          fail_next  = 1'b1;
          state_next = REL;
        end else begin
          if (phi == PHI_RD)  mem_rd    = 1'b1;
          if (phi == PHI_CAP) data_next = mem_din;
          if (phi == PHI_WR) begin
            obj_wr     = 1'b1;
            count_next = count_inc;
            if (count_inc == len) state_next = REL;
          end
        end
      end
      REL: begin
        if (busack_n) state_next = DONE;
      end
      DONE: begin
        if (!fail_reg) begin
          done_irq  = 1'b1;
          psl2_next = ~psl2_reg;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state_reg inside {ARM, REQ, XFER, REL});
  assign obj_addr = count_reg;
  assign obj_dout = data_reg;
  assign psl2     = psl2_reg;

endmodule

// File: tb/tb_sprite_dma_ctrl.sv
// Directed bench for sprite_dma_ctrl with a latched work-RAM model and a
// Z80 bus-acknowledge responder.
module tb_sprite_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  phi = 3'd0;
  logic        vblank, cfg_wr;
  logic [1:0]  cfg_sel;
  logic [7:0]  cfg_din;
  logic        busrq_n;
  logic        busack_n = 1'b1;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_din = 8'h00;
  logic [9:0]  obj_addr;
  logic        obj_wr;
  logic [7:0]  obj_dout;
  logic        psl2, busy, done_irq;

  int errors = 0;
  int checks = 0;

  // Upper length bits are zero here so a len_lo write alone sets the byte count.
  sprite_dma_ctrl #(.DEFAULT_LEN(10'h080)) dut (
    .clk(clk), .rst_n(rst_n), .phi(phi), .vblank(vblank),
    .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_din(cfg_din),
    .busrq_n(busrq_n), .busack_n(busack_n),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_din(mem_din),
    .obj_addr(obj_addr), .obj_wr(obj_wr), .obj_dout(obj_dout),
    .psl2(psl2), .busy(busy), .done_irq(done_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) phi <= 3'd0;
    else        phi <= (phi == 3'd3) ? 3'd0 : phi + 3'd1;
  end

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(posedge clk) if (mem_rd) mem_din <= mem_val(mem_addr);

  // Acknowledge three cycles into a request, release one cycle after it drops.
  int ack_cnt = 0;
  always @(posedge clk) begin
    if (busrq_n) begin
      ack_cnt  <= 0;
      busack_n <= 1'b1;
    end else if (ack_cnt >= 2) busack_n <= 1'b0;
    else ack_cnt <= ack_cnt + 1;
  end

  logic [9:0]  wr_addr_log [0:1023];
  logic [7:0]  wr_data_log [0:1023];
  logic [15:0] rd_addr_log [0:1023];
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, rq_cnt = 0;

  always @(negedge clk) begin
    if (obj_wr) begin
      wr_addr_log[wr_cnt] = obj_addr;
      wr_data_log[wr_cnt] = obj_dout;
      wr_cnt = wr_cnt + 1;
    end
    if (mem_rd) begin
      rd_addr_log[rd_cnt] = mem_addr;
      rd_cnt = rd_cnt + 1;
    end
    if (done_irq) done_cnt = done_cnt + 1;
    if (!busrq_n) rq_cnt = rq_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [7:0] din);
    cfg_wr  = 1'b1;
    cfg_sel = sel;
    cfg_din = din;
    step(1);
    cfg_wr  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((busy || !busrq_n || !busack_n) && n < budget) begin
      step(1);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles", tag, n);
    end
    step(3);
  endtask

  task automatic wait_writes(input int target, input int budget, input string tag);
    int n = 0;
    while (wr_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    checks++;
    if (wr_cnt < target) begin
      errors++;
      $display("FAIL %s_wait: writes=%0d required %0d", tag, wr_cnt, target);
    end
  endtask

  task automatic test_reset();
    checks += 6;
    if (busrq_n !== 1'b1)  begin errors++; $display("FAIL reset_busrq_n: got %b expected 1", busrq_n); end
    if (mem_rd !== 1'b0)   begin errors++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
    if (obj_wr !== 1'b0)   begin errors++; $display("FAIL reset_obj_wr: got %b expected 0", obj_wr); end
    if (psl2 !== 1'b0)     begin errors++; $display("FAIL reset_psl2: got %b expected 0", psl2); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (done_irq !== 1'b0) begin errors++; $display("FAIL reset_done_irq: got %b expected 0", done_irq); end
    $display("test_reset: outputs checked after reset");
  endtask

  task automatic test_happy_path();
    logic [7:0] exp_data [4] = '{8'h2A, 8'h2B, 8'h28, 8'h29};
    int wb = wr_cnt, db = done_cnt;
    vblank = 1'b0;
    cfg_write(2'd0, 8'h00);
    cfg_write(2'd1, 8'h70);
    cfg_write(2'd2, 8'h04);
    cfg_write(2'd3, 8'h01);
    step(4);
    vblank = 1'b1;
    wait_idle(300, "happy");
    checks++;
    if (wr_cnt - wb !== 4) begin errors++; $display("FAIL happy_count: writes=%0d expected 4", wr_cnt - wb); end
    for (int i = 0; i < 4; i++) begin
      checks += 2;
      if (wr_addr_log[wb+i] !== 10'(i)) begin
        errors++; $display("FAIL happy_addr%0d: got %0h expected %0h", i, wr_addr_log[wb+i], i);
      end
      if (wr_data_log[wb+i] !== exp_data[i]) begin
        errors++; $display("FAIL happy_data%0d: got %0h expected %0h", i, wr_data_log[wb+i], exp_data[i]);
      end
    end
    checks += 3;
    if (psl2 !== 1'b1)       begin errors++; $display("FAIL happy_psl2: got %b expected 1", psl2); end
    if (done_cnt - db !== 1) begin errors++; $display("FAIL happy_done: got %0d expected 1", done_cnt - db); end
    if (busrq_n !== 1'b1)    begin errors++; $display("FAIL happy_busrq_n: got %b expected 1", busrq_n); end
    $display("test_happy_path: src=7000 len=4 writes=%0d psl2=%b", wr_cnt - wb, psl2);
  endtask

  task automatic test_start_outside_vblank();
    int wb = wr_cnt, db = done_cnt, rqb = rq_cnt, rb = rd_cnt;
    vblank = 1'b0;
    cfg_write(2'd2, 8'h02);
    cfg_write(2'd3, 8'h01);
    step(20);
    checks += 3;
    if (rq_cnt - rqb !== 0) begin errors++; $display("FAIL novb_busrq: low cycles=%0d expected 0", rq_cnt - rqb); end
    if (rd_cnt - rb !== 0)  begin errors++; $display("FAIL novb_mem_rd: reads=%0d expected 0", rd_cnt - rb); end
    if (busy !== 1'b1)      begin errors++; $display("FAIL novb_busy: got %b expected 1", busy); end
    vblank = 1'b1;
    wait_idle(300, "novb");
    checks += 3;
    if (wr_cnt - wb !== 2)   begin errors++; $display("FAIL novb_count: writes=%0d expected 2", wr_cnt - wb); end
    if (done_cnt - db !== 1) begin errors++; $display("FAIL novb_done: got %0d expected 1", done_cnt - db); end
    if (psl2 !== 1'b0)       begin errors++; $display("FAIL novb_psl2: got %b expected 0", psl2); end
    $display("test_start_outside_vblank: writes=%0d psl2=%b", wr_cnt - wb, psl2);
  endtask

  task automatic test_abort();
    int wb = wr_cnt, db = done_cnt;
    logic psl_before = psl2;
    vblank = 1'b1;
    cfg_write(2'd2, 8'h06);
    cfg_write(2'd3, 8'h01);
    wait_writes(wb + 2, 300, "abort");
    cfg_write(2'd3, 8'h02);
    wait_idle(300, "abort");
    step(8);
    checks += 4;
    if (wr_cnt - wb !== 2)   begin errors++; $display("FAIL abort_count: writes=%0d expected 2", wr_cnt - wb); end
    if (done_cnt - db !== 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", done_cnt - db); end
    if (psl2 !== psl_before) begin errors++; $display("FAIL abort_psl2: got %b expected %b", psl2, psl_before); end
    if (busrq_n !== 1'b1)    begin errors++; $display("FAIL abort_busrq_n: got %b expected 1", busrq_n); end
    $display("test_abort: writes=%0d before release", wr_cnt - wb);
  endtask

  task automatic test_vblank_loss();
    int wb = wr_cnt, db = done_cnt;
    logic psl_before = psl2;
    vblank = 1'b1;
    cfg_write(2'd2, 8'h04);
    cfg_write(2'd3, 8'h01);
    wait_writes(wb + 1, 300, "vbloss");
    vblank = 1'b0;
    wait_idle(300, "vbloss");
    checks += 3;
    if (wr_cnt - wb !== 4)   begin errors++; $display("FAIL vbloss_count: writes=%0d expected 4", wr_cnt - wb); end
    if (done_cnt - db !== 0) begin errors++; $display("FAIL vbloss_done: got %0d expected 0", done_cnt - db); end
    if (psl2 !== psl_before) begin errors++; $display("FAIL vbloss_psl2: got %b expected %b", psl2, psl_before); end
    vblank = 1'b1;
    $display("test_vblank_loss: writes=%0d psl2=%b", wr_cnt - wb, psl2);
  endtask

  task automatic test_wrap();
    logic [15:0] exp_addr [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    int rb = rd_cnt, db = done_cnt;
    cfg_write(2'd0, 8'hFE);
    cfg_write(2'd1, 8'hFF);
    cfg_write(2'd2, 8'h04);
    cfg_write(2'd3, 8'h01);
    wait_idle(300, "wrap");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_addr_log[rb+i] !== exp_addr[i]) begin
        errors++; $display("FAIL wrap_addr%0d: got %h expected %h", i, rd_addr_log[rb+i], exp_addr[i]);
      end
    end
    checks++;
    if (done_cnt - db !== 1) begin errors++; $display("FAIL wrap_done: got %0d expected 1", done_cnt - db); end
    $display("test_wrap: reads=%0d", rd_cnt - rb);
  endtask

  task automatic test_zero_len();
    int wb = wr_cnt, db = done_cnt, rqb = rq_cnt;
    cfg_write(2'd2, 8'h00);
    cfg_write(2'd3, 8'h01);
    step(6);
    checks += 4;
    if (done_cnt - db !== 1) begin errors++; $display("FAIL zero_done: got %0d expected 1", done_cnt - db); end
    if (rq_cnt - rqb !== 0)  begin errors++; $display("FAIL zero_busrq: low cycles=%0d expected 0", rq_cnt - rqb); end
    if (wr_cnt - wb !== 0)   begin errors++; $display("FAIL zero_count: writes=%0d expected 0", wr_cnt - wb); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL zero_busy: got %b expected 0", busy); end
    $display("test_zero_len: done pulses=%0d", done_cnt - db);
  endtask

  task automatic test_ignored_writes();
    int wb = wr_cnt, rb = rd_cnt;
    vblank = 1'b0;
    cfg_write(2'd0, 8'h00);
    cfg_write(2'd1, 8'h10);
    cfg_write(2'd2, 8'h04);
    cfg_write(2'd3, 8'h01);
    step(2);
    cfg_write(2'd0, 8'h55);
    cfg_write(2'd3, 8'h01);
    vblank = 1'b1;
    wait_idle(300, "ignored");
    checks += 4;
    if (rd_addr_log[rb] !== 16'h1000)   begin errors++; $display("FAIL ignored_src: got %h expected 1000", rd_addr_log[rb]); end
    if (rd_addr_log[rb+3] !== 16'h1003) begin errors++; $display("FAIL ignored_src_last: got %h expected 1003", rd_addr_log[rb+3]); end
    if (wr_cnt - wb !== 4)              begin errors++; $display("FAIL ignored_count: writes=%0d expected 4", wr_cnt - wb); end
    if (wr_data_log[wb] !== 8'h4A)      begin errors++; $display("FAIL ignored_data: got %h expected 4a", wr_data_log[wb]); end
    $display("test_ignored_writes: first read %h", rd_addr_log[rb]);
  endtask

  task automatic test_reset_mid_xfer();
    int wb = wr_cnt;
    vblank = 1'b1;
    cfg_write(2'd2, 8'h08);
    cfg_write(2'd3, 8'h01);
    wait_writes(wb + 1, 300, "midrst");
    rst_n = 1'b0;
    step(1);
    checks += 3;
    if (busrq_n !== 1'b1) begin errors++; $display("FAIL midrst_busrq_n: got %b expected 1", busrq_n); end
    if (busy !== 1'b0)    begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    if (obj_wr !== 1'b0)  begin errors++; $display("FAIL midrst_obj_wr: got %b expected 0", obj_wr); end
    rst_n = 1'b1;
    step(5);
    $display("test_reset_mid_xfer: busrq_n=%b busy=%b", busrq_n, busy);
  endtask

  task automatic test_default_len();
    int wb = wr_cnt, db = done_cnt;
    vblank = 1'b1;
    cfg_write(2'd3, 8'h01);
    wait_idle(2000, "deflen");
    checks += 5;
    if (wr_cnt - wb !== 128)            begin errors++; $display("FAIL deflen_count: writes=%0d expected 128", wr_cnt - wb); end
    if (wr_addr_log[wb+127] !== 10'h07F) begin errors++; $display("FAIL deflen_last_addr: got %h expected 07f", wr_addr_log[wb+127]); end
    if (wr_data_log[wb+127] !== 8'h25)  begin errors++; $display("FAIL deflen_last_data: got %h expected 25", wr_data_log[wb+127]); end
    if (psl2 !== 1'b1)                  begin errors++; $display("FAIL deflen_psl2: got %b expected 1", psl2); end
    if (done_cnt - db !== 1)            begin errors++; $display("FAIL deflen_done: got %0d expected 1", done_cnt - db); end
    $display("test_default_len: writes=%0d", wr_cnt - wb);
  endtask

  initial begin
    rst_n   = 1'b0;
    vblank  = 1'b0;
    cfg_wr  = 1'b0;
    cfg_sel = 2'd0;
    cfg_din = 8'h00;
    step(3);
    rst_n = 1'b1;
    step(1);
    test_reset();
    test_happy_path();
    test_start_outside_vblank();
    test_abort();
    test_vblank_loss();
    test_wrap();
    test_zero_len();
    test_ignored_writes();
    test_reset_mid_xfer();
    test_default_len();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
